unary_stream_decoder: RTL and testbench

UNARY_STREAM_DECODER -- requirements
Module: unary_stream_decoder

---
 rtl/unary_pkg.sv | 15 +
 rtl/unary_stream_decoder_if.sv | 24 ++
 rtl/unary_lane_counter.sv | 48 ++++
 rtl/unary_stream_decoder.sv | 86 ++++++++
 tb/tb_unary_stream_decoder.sv | 353 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/unary_pkg.sv
// Shared types and sizing for the unary stream decoder slice.
package unary_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // A window of 2**win_w samples needs one extra bit so an all-ones lane reads back exactly 2**win_w.
  function automatic int unsigned count_width(input int unsigned win_w);
    return win_w + 1;
  endfunction

endpackage

// File: rtl/unary_stream_decoder_if.sv
// Bundle of the decoder's stream-side handshake and result signals.
interface unary_stream_decoder_if #(
  parameter int unsigned LANES = 4,
  parameter int unsigned WIN_W = 4
);
  logic                        start;
  logic [LANES-1:0]            bits_in;
  logic                        bits_valid;
  logic                        out_ready;
  logic                        busy;
  logic                        out_valid;
  logic [LANES-1:0][WIN_W:0]   out;
  logic [LANES-1:0]            err;

  modport master (
    output start, bits_in, bits_valid, out_ready,
    input  busy, out_valid, out, err
  );

  modport slave (
    input  start, bits_in, bits_valid, out_ready,
    output busy, out_valid, out, err
  );
endinterface

// File: rtl/unary_lane_counter.sv
// One lane: counts ones in the window and flags a non-temporal (1..0..1) shape.
module unary_lane_counter
  import unary_pkg::*;
#(
  parameter int unsigned WIN_W = 4
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              clear,
  input  logic                              sample_en,
  input  logic                              bit_in,
  output logic [count_width(WIN_W)-1:0]     count,
  output logic                              err
);
  localparam int unsigned CW = count_width(WIN_W);

  logic [CW-1:0] count_q;
  logic          err_q;
  logic          prev_q;
  logic          fell_q;

  // prev_q starts at 0, so the first sample of a window can never register a fall.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count_q <= '0;
      err_q   <= 1'b0;
      prev_q  <= 1'b0;
      fell_q  <= 1'b0;
    end else if (clear) begin
      count_q <= '0;
      err_q   <= 1'b0;
      prev_q  <= 1'b0;
      fell_q  <= 1'b0;
    end else if (sample_en) begin
      count_q <= count_q + CW'(bit_in);
      prev_q  <= bit_in;
      if (prev_q && !bit_in) fell_q <= 1'b1;
      // Once a fall was seen the line is at 0, so any later 1 is a rise after a fall.
      if (fell_q && bit_in) err_q <= 1'b1;
    end
  end

  always_comb begin
    count = count_q;
    err   = err_q;
  end

endmodule

// File: rtl/unary_stream_decoder.sv
// Window-based decoder of LANES temporal/unary bit streams into per-lane counts.
module unary_stream_decoder
  import unary_pkg::*;
#(
  parameter int unsigned LANES = 4,
  parameter int unsigned WIN_W = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      start,
  input  logic [LANES-1:0]          bits_in,
  input  logic                      bits_valid,
  input  logic                      out_ready,
  output logic                      busy,
  output logic                      out_valid,
  output logic [LANES-1:0][WIN_W:0] out,
  output logic [LANES-1:0]          err
);
  state_t           state_q, state_d;
  logic [WIN_W-1:0] samp_q;
  logic             clear;
  logic             sample_en;
  logic             last_sample;

  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    clear       = 1'b0;
    sample_en   = 1'b0;
    last_sample = &samp_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          clear   = 1'b1;
          state_d = COUNT;
        end
      end
      COUNT: begin
        sample_en = bits_valid;
        if (bits_valid && last_sample) state_d = DONE;
      end
      DONE: begin
        if (out_ready) begin
          if (start) begin
            clear   = 1'b1;
            state_d = COUNT;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Sample counter wraps to 0 on the window's final sample; DONE is driven by the all-ones compare.
  always_ff @(posedge clk) begin
    if (!reset_n)       samp_q <= '0;
    else if (clear)     samp_q <= '0;
    else if (sample_en) samp_q <= samp_q + WIN_W'(1);
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    unary_lane_counter #(
      .WIN_W (WIN_W)
    ) u_lane (
      .clk       (clk),
      .reset_n   (reset_n),
      .clear     (clear),
      .sample_en (sample_en),
      .bit_in    (bits_in[i]),
      .count     (out[i]),
      .err       (err[i])
    );
  end

  always_comb begin
    busy      = (state_q == COUNT);
    out_valid = (state_q == DONE);
  end

endmodule

// File: tb/tb_unary_stream_decoder.sv
// Randomized self-checking bench for unary_stream_decoder against a window-level model.
module tb_unary_stream_decoder;
  localparam int unsigned LANES = 4;
  localparam int unsigned WIN_W = 4;
  localparam int NS = 16;

  typedef logic [LANES-1:0][WIN_W:0] out_t;

  logic clk = 1'b0;
  logic reset_n;
  int   vectors = 0;
  int   miscompares = 0;

  logic [LANES-1:0] win [NS];
  int               codes [LANES];

  unary_stream_decoder_if #(.LANES(LANES), .WIN_W(WIN_W)) dif ();

  unary_stream_decoder #(
    .LANES (LANES),
    .WIN_W (WIN_W)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (dif.start),
    .bits_in    (dif.bits_in),
    .bits_valid (dif.bits_valid),
    .out_ready  (dif.out_ready),
    .busy       (dif.busy),
    .out_valid  (dif.out_valid),
    .out        (dif.out),
    .err        (dif.err)
  );

  always #5 clk = ~clk;

  // Model: count = number of ones; err = a 1 occurs somewhere after a 0 that follows an earlier 1.
  function automatic out_t model_out();
    out_t r;
    r = '0;
    for (int l = 0; l < LANES; l++) begin
      int n;
      n = 0;
      for (int j = 0; j < NS; j++) if (win[j][l]) n++;
      r[l] = (WIN_W+1)'(n);
    end
    return r;
  endfunction

  function automatic logic [LANES-1:0] model_err();
    logic [LANES-1:0] r;
    r = '0;
    for (int l = 0; l < LANES; l++) begin
      int first_one, zero_after;
      first_one  = -1;
      zero_after = -1;
      for (int j = 0; j < NS; j++) begin
        if (first_one < 0 && win[j][l]) first_one = j;
        else if (first_one >= 0 && zero_after < 0 && !win[j][l]) zero_after = j;
        else if (zero_after >= 0 && win[j][l]) r[l] = 1'b1;
      end
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_thermo();
    for (int j = 0; j < NS; j++)
      for (int l = 0; l < LANES; l++)
        win[j][l] = (j < codes[l]);
  endtask

  task automatic fill_random();
    for (int l = 0; l < LANES; l++) codes[l] = int'($urandom_range(0, NS));
    fill_thermo();
    if ($urandom_range(0, 1) == 1)
      for (int j = 0; j < NS; j++) win[j] = LANES'($urandom);
  endtask

  task automatic do_start();
    dif.start      = 1'b1;
    dif.bits_valid = 1'b0;
    tick();
    dif.start = 1'b0;
  endtask

  task automatic feed(input int from, input int to);
    for (int j = from; j < to; j++) begin
      dif.bits_in    = win[j];
      dif.bits_valid = 1'b1;
      tick();
    end
    dif.bits_valid = 1'b0;
    dif.bits_in    = LANES'($urandom);
  endtask

  task automatic drain();
    dif.out_ready = 1'b1;
    tick();
    dif.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    for (int c = 0; c < 2; c++) begin
      dif.start      = 1'($urandom);
      dif.bits_valid = 1'($urandom);
      dif.out_ready  = 1'($urandom);
      dif.bits_in    = LANES'($urandom);
      tick();
    end
    vectors++;
    if (dif.out !== '0 || dif.err !== '0 || dif.out_valid !== 1'b0 || dif.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset: out=%h err=%b out_valid=%b busy=%b, required all zero",
               dif.out, dif.err, dif.out_valid, dif.busy);
    end
    dif.start = 1'b0; dif.bits_valid = 1'b0; dif.out_ready = 1'b0;
    reset_n = 1'b1;
    tick();
    vectors++;
    if (dif.busy !== 1'b0 || dif.out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release_idle: busy=%b out_valid=%b, required 0/0", dif.busy, dif.out_valid);
    end
  endtask

  task automatic test_basic();
    out_t exp_out;
    codes[0] = 3; codes[1] = 0; codes[2] = 16; codes[3] = 7;
    fill_thermo();
    exp_out = model_out();
    do_start();
    vectors++;
    if (dif.busy !== 1'b1) begin
      miscompares++;
      $display("FAIL basic_busy_after_start: busy=%b, required 1", dif.busy);
    end
    feed(0, NS-1);
    vectors++;
    if (dif.out_valid !== 1'b0 || dif.busy !== 1'b1) begin
      miscompares++;
      $display("FAIL basic_before_last: out_valid=%b busy=%b, required 0/1", dif.out_valid, dif.busy);
    end
    feed(NS-1, NS);
    vectors++;
    if (dif.out_valid !== 1'b1 || dif.busy !== 1'b0 || dif.out !== exp_out || dif.err !== '0) begin
      miscompares++;
      $display("FAIL basic_result: out_valid=%b busy=%b out=%h err=%b, required 1/0 out=%h err=0",
               dif.out_valid, dif.busy, dif.out, dif.err, exp_out);
    end
    drain();
    vectors++;
    if (dif.out_valid !== 1'b0 || dif.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_drain: out_valid=%b busy=%b, required 0/0", dif.out_valid, dif.busy);
    end
  endtask

  task automatic test_stall();
    out_t exp_out;
    codes[0] = 3; codes[1] = 0; codes[2] = 16; codes[3] = 7;
    fill_thermo();
    exp_out = model_out();
    do_start();
    feed(0, 8);
    for (int c = 0; c < 5; c++) begin
      dif.bits_in    = LANES'($urandom);
      dif.bits_valid = 1'b0;
      tick();
      vectors++;
      if (dif.busy !== 1'b1 || dif.out_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL stall_cycle%0d: busy=%b out_valid=%b, required 1/0", c, dif.busy, dif.out_valid);
      end
    end
    feed(8, NS-1);
    vectors++;
    if (dif.out_valid !== 1'b0 || dif.busy !== 1'b1) begin
      miscompares++;
      $display("FAIL stall_before_last: out_valid=%b busy=%b, required 0/1", dif.out_valid, dif.busy);
    end
    feed(NS-1, NS);
    vectors++;
    if (dif.out_valid !== 1'b1 || dif.out !== exp_out || dif.err !== '0) begin
      miscompares++;
      $display("FAIL stall_result: out_valid=%b out=%h err=%b, required 1 out=%h err=0",
               dif.out_valid, dif.out, dif.err, exp_out);
    end
    drain();
  endtask

  task automatic test_err();
    out_t             exp_out;
    logic [LANES-1:0] exp_err;
    for (int l = 1; l < LANES; l++) codes[l] = int'($urandom_range(0, NS));
    codes[0] = 0;
    fill_thermo();
    win[0][0] = 1'b1; win[1][0] = 1'b0; win[2][0] = 1'b1;
    exp_out = model_out();
    exp_err = model_err();
    do_start();
    feed(0, NS);
    vectors++;
    if (dif.out_valid !== 1'b1 || dif.out[0] !== 5'd2 || dif.err !== 4'b0001 || dif.out !== exp_out || dif.err !== exp_err) begin
      miscompares++;
      $display("FAIL err_detect: out_valid=%b out=%h err=%b, required 1 out=%h (lane0=2) err=0001",
               dif.out_valid, dif.out, dif.err, exp_out);
    end
    drain();
  endtask

  task automatic test_random();
    out_t             exp_out;
    logic [LANES-1:0] exp_err;
    for (int w = 0; w < 6; w++) begin
      fill_random();
      exp_out = model_out();
      exp_err = model_err();
      do_start();
      for (int j = 0; j < NS; j++) begin
        for (int g = 0; g < 3 && $urandom_range(0, 2) == 0; g++) begin
          dif.bits_in    = LANES'($urandom);
          dif.bits_valid = 1'b0;
          tick();
          vectors++;
          if (dif.busy !== 1'b1 || dif.out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL random%0d_gap: busy=%b out_valid=%b, required 1/0", w, dif.busy, dif.out_valid);
          end
        end
        feed(j, j+1);
      end
      vectors++;
      if (dif.out_valid !== 1'b1 || dif.out !== exp_out || dif.err !== exp_err) begin
        miscompares++;
        $display("FAIL random%0d_result: out_valid=%b out=%h err=%b, required 1 out=%h err=%b",
                 w, dif.out_valid, dif.out, dif.err, exp_out, exp_err);
      end
      drain();
    end
  endtask

  task automatic test_back_to_back();
    out_t             exp_out;
    logic [LANES-1:0] exp_err;
    fill_random();
    exp_out = model_out();
    exp_err = model_err();
    do_start();
    feed(0, NS);
    for (int c = 0; c < 10; c++) begin
      dif.out_ready  = 1'b0;
      dif.start      = 1'($urandom_range(0, 1));
      dif.bits_valid = 1'($urandom);
      dif.bits_in    = LANES'($urandom);
      tick();
      vectors++;
      if (dif.out_valid !== 1'b1 || dif.busy !== 1'b0 || dif.out !== exp_out || dif.err !== exp_err) begin
        miscompares++;
        $display("FAIL backpressure_hold%0d: out_valid=%b busy=%b out=%h err=%b, required 1/0 out=%h err=%b",
                 c, dif.out_valid, dif.busy, dif.out, dif.err, exp_out, exp_err);
      end
    end
    fill_random();
    exp_out = model_out();
    exp_err = model_err();
    dif.bits_valid = 1'b0;
    dif.out_ready  = 1'b1;
    dif.start      = 1'b1;
    tick();
    dif.out_ready = 1'b0;
    dif.start     = 1'b0;
    vectors++;
    if (dif.busy !== 1'b1 || dif.out_valid !== 1'b0 || dif.out !== '0 || dif.err !== '0) begin
      miscompares++;
      $display("FAIL b2b_restart: busy=%b out_valid=%b out=%h err=%b, required 1/0 out=0 err=0",
               dif.busy, dif.out_valid, dif.out, dif.err);
    end
    feed(0, NS);
    vectors++;
    if (dif.out_valid !== 1'b1 || dif.out !== exp_out || dif.err !== exp_err) begin
      miscompares++;
      $display("FAIL b2b_result: out_valid=%b out=%h err=%b, required 1 out=%h err=%b",
               dif.out_valid, dif.out, dif.err, exp_out, exp_err);
    end
    drain();
  endtask

  task automatic test_reset_mid();
    out_t             exp_out;
    logic [LANES-1:0] exp_err;
    fill_random();
    do_start();
    feed(0, 9);
    reset_n        = 1'b0;
    dif.start      = 1'b1;
    dif.bits_valid = 1'b1;
    dif.out_ready  = 1'b1;
    tick();
    vectors++;
    if (dif.busy !== 1'b0 || dif.out_valid !== 1'b0 || dif.out !== '0 || dif.err !== '0) begin
      miscompares++;
      $display("FAIL reset_mid: busy=%b out_valid=%b out=%h err=%b, required all zero",
               dif.busy, dif.out_valid, dif.out, dif.err);
    end
    reset_n        = 1'b1;
    dif.start      = 1'b0;
    dif.out_ready  = 1'b0;
    dif.bits_in    = '1;
    tick();
    dif.bits_valid = 1'b0;
    vectors++;
    if (dif.busy !== 1'b0 || dif.out !== '0) begin
      miscompares++;
      $display("FAIL reset_mid_idle_ignores: busy=%b out=%h, required 0 out=0", dif.busy, dif.out);
    end
    fill_random();
    exp_out = model_out();
    exp_err = model_err();
    do_start();
    feed(0, NS);
    vectors++;
    if (dif.out_valid !== 1'b1 || dif.out !== exp_out || dif.err !== exp_err) begin
      miscompares++;
      $display("FAIL reset_mid_fresh: out_valid=%b out=%h err=%b, required 1 out=%h err=%b",
               dif.out_valid, dif.out, dif.err, exp_out, exp_err);
    end
    drain();
  endtask

  initial begin
    reset_n        = 1'b0;
    dif.start      = 1'b0;
    dif.bits_in    = '0;
    dif.bits_valid = 1'b0;
    dif.out_ready  = 1'b0;
    test_reset();
    test_basic();
    test_stall();
    test_err();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
